truth_table_sweeper: RTL and testbench

- Sequencer that exhaustively exercises the 5-input minimized logic block (inputs a, b, c, d, s; output o).
- Steps all 32 input vectors, waits a programmable settle time per vector, samples o, and compares against a golden truth table.
- Reports the captured table, the mismatch count and the first failing vector.
- Sits between the bench/control layer and the combinational function under test.

---
 rtl/truth_table_sweeper.sv | 110 +++++++++++
 tb/tb_truth_table_sweeper.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for a 5-input combinational block.
// Walks all 32 input vectors, waits a settle time on each, samples o and scores it against EXPECT.
module truth_table_sweeper #(
    parameter logic [31:0] EXPECT = 32'h2CE9_4767,
    parameter int          CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] settle,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             d_o,
    output logic             s_o,
    input  logic             o_i,
    output logic             busy,
    output logic             done,
    output logic [31:0]      captured,
    output logic [5:0]       mismatch_cnt,
    output logic             first_fail_valid,
    output logic [4:0]       first_fail_idx,
    output logic             pass
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [4:0]       LAST_IDX = 5'd31;

    state_t           state_q, state_d;
    logic [4:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] settle_q;
    logic             miss;
    logic             settle_end;
    logic [5:0]       mismatch_nxt;

    assign {s_o, a_o, b_o, c_o, d_o} = idx;

    assign miss         = (o_i != EXPECT[idx]);
    assign settle_end   = (cnt == settle_q - ONE);
    assign mismatch_nxt = mismatch_cnt + {5'd0, miss};

    assign busy = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (abort) state_d = IDLE;
                     else if (settle_end) state_d = SAMPLE;
            SAMPLE:  if (abort) state_d = IDLE;
                     else if (idx == LAST_IDX) state_d = DONE;
                     else state_d = SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort wins over both counter advance and the sample update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= '0;
            cnt              <= '0;
            settle_q         <= '0;
            captured         <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            pass             <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    idx              <= '0;
                    cnt              <= '0;
                    settle_q         <= (settle == '0) ? ONE : settle;
                    captured         <= '0;
                    mismatch_cnt     <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_idx   <= '0;
                    pass             <= 1'b0;
                end
                SETTLE: if (!abort) begin
                    cnt <= settle_end ? '0 : cnt + ONE;
                end
                SAMPLE: if (!abort) begin
                    captured[idx] <= o_i;
                    mismatch_cnt  <= mismatch_nxt;
                    if (miss && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                    // pass is resolved on the edge into DONE so it is visible alongside done.
                    if (idx == LAST_IDX) pass <= (mismatch_nxt == 6'd0);
                    else                 idx  <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a table-driven DUT model feeds o_i,
// expected sweep results are queued at start and checked by a monitor on done.
module tb_truth_table_sweeper;

    localparam logic [31:0] GOLD = 32'h2CE9_4767;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  settle = 4'd0;
    logic        a_o, b_o, c_o, d_o, s_o, o_i;
    logic        busy, done, first_fail_valid, pass;
    logic [31:0] captured;
    logic [5:0]  mismatch_cnt;
    logic [4:0]  first_fail_idx;

    logic [31:0] tbl = 32'd0;
    logic [31:0] gold = GOLD;
    logic [4:0]  vec;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] cap;
        int          mm;
        bit          ffv;
        int          ffi;
        bit          pass;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    truth_table_sweeper #(.EXPECT(GOLD), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .settle(settle),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o), .s_o(s_o), .o_i(o_i),
        .busy(busy), .done(done), .captured(captured), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx), .pass(pass)
    );

    // Function under test: pure table lookup on the driven vector.
    assign vec = {s_o, a_o, b_o, c_o, d_o};
    assign o_i = tbl[vec];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Expected results after the first n vectors have been sampled.
    function automatic exp_t model(input logic [31:0] t, input int n);
        exp_t e;
        e.cap = '0; e.mm = 0; e.ffv = 0; e.ffi = 0; e.t0 = 0; e.lat = 0;
        for (int k = 0; k < n; k++) begin
            e.cap[k] = t[k];
            if (t[k] !== gold[k]) begin
                e.mm++;
                if (!e.ffv) begin e.ffv = 1; e.ffi = k; end
            end
        end
        e.pass = (n == 32) && (e.mm == 0);
        return e;
    endfunction

    function automatic int eff_settle(input int st);
        return (st == 0) ? 1 : st;
    endfunction

    // Monitor: walk/busy tracking and scoreboard pop on done.
    initial begin
        exp_t e;
        int   busy_cnt;
        int   walk[$];
        bit   prev_busy;
        bit   ok;
        busy_cnt = 0; prev_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 0;
            end else begin
                if (busy && !prev_busy) begin busy_cnt = 0; walk.delete(); end
                prev_busy = busy;
                if (busy) begin
                    busy_cnt++;
                    if (walk.size() == 0 || walk[$] != int'(vec)) walk.push_back(int'(vec));
                end
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else if (done) begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.t0, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat);
                    chk("captured", captured, e.cap);
                    chk("mismatch_cnt", mismatch_cnt, e.mm);
                    chk("first_fail_valid", first_fail_valid, e.ffv);
                    if (e.ffv) chk("first_fail_idx", first_fail_idx, e.ffi);
                    chk("pass", pass, e.pass);
                    chk("idx_at_done", vec, 31);
                    ok = (walk.size() == 32);
                    for (int k = 0; k < walk.size() && k < 32; k++)
                        if (walk[k] != k) ok = 0;
                    chk("walk", ok, 1);
                end
            end
        end
    end

    task automatic launch(input logic [31:0] t, input int st, input bit with_abort, input bit expect_done);
        exp_t e;
        tbl = t;
        settle = 4'(st);
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (expect_done) begin
            e = model(t, 32);
            e.t0 = cyc;
            e.lat = 32 * (eff_settle(st) + 1);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int st);
        int budget;
        budget = 32 * (eff_settle(st) + 1) + 20;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic sweep(input logic [31:0] t, input int st);
        launch(t, st, 1'b0, 1'b1);
        wait_done(st);
    endtask

    // Abort with S=1 while idx=10: in its SETTLE cycle, or in its SAMPLE cycle.
    task automatic abort_run(input logic [31:0] t, input bit in_sample);
        exp_t e;
        bit   found;
        launch(t, 1, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy && vec == 5'd10) begin found = 1; break; end
        end
        chk("abort_reached_idx10", found, 1);
        if (in_sample) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        e = model(t, 10);
        chk("abort_busy", busy, 0);
        chk("abort_captured", captured, e.cap);
        chk("abort_mismatch", mismatch_cnt, e.mm);
        chk("abort_ffv", first_fail_valid, e.ffv);
        if (e.ffv) chk("abort_ffi", first_fail_idx, e.ffi);
        chk("abort_pass", pass, 0);
        repeat (80) @(negedge clk);
        chk("abort_hold_captured", captured, e.cap);
    endtask

    initial begin
        logic [31:0] t;
        int          st;

        #2;
        chk("rst_drives", vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_captured", captured, 0);
        chk("rst_mismatch", mismatch_cnt, 0);
        chk("rst_ffv", first_fail_valid, 0);
        chk("rst_ffi", first_fail_idx, 0);
        chk("rst_pass", pass, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(GOLD, 3);
        sweep(32'h0, 2);
        sweep(32'hFFFF_FFFF, 1);
        sweep(GOLD, 0);

        // abort in IDLE must not disturb held results
        @(negedge clk);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_pass", pass, 1);
        chk("idle_abort_captured", captured, GOLD);

        for (int r = 0; r < 6; r++) begin
            st = $urandom_range(0, 15);
            case (r % 3)
                0:       t = $urandom;
                1:       t = GOLD ^ (32'd1 << $urandom_range(0, 31));
                default: t = GOLD ^ ($urandom & $urandom & $urandom);
            endcase
            sweep(t, st);
        end

        // start and abort together in IDLE: start wins
        launch(GOLD ^ 32'h8000_0000, 2, 1'b1, 1'b1);
        wait_done(2);

        t = $urandom;
        t[10] = 1'b0;
        abort_run(t, 1'b0);
        t[10] = 1'b1;
        abort_run(t, 1'b1);
        t = $urandom;
        t[10] = 1'b0;
        abort_run(t, 1'b1);
        sweep(GOLD, 2);

        // start re-pulse and settle change mid-sweep are ignored
        launch(GOLD ^ 32'h0001_0000, 2, 1'b0, 1'b1);
        repeat (19) @(negedge clk);
        start = 1'b1;
        settle = 4'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(2);

        // asynchronous reset mid-sweep
        launch(32'h0, 3, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_drives", vec, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_captured", captured, 0);
        chk("midrst_mismatch", mismatch_cnt, 0);
        chk("midrst_ffv", first_fail_valid, 0);
        chk("midrst_ffi", first_fail_idx, 0);
        chk("midrst_pass", pass, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sweep(GOLD, 1);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d cycles want finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
